// File: rtl/mem_bus_master.sv
// mem_bus_master
//   Bus initiator for the memory_5x8 port. Takes one read, write or
//   instruction-fetch request at a time over valid/ready. It sequences
//   sel/rd/wr/ld_ir, drives data_e only while writing, captures read data
//   and returns a one-cycle rsp_valid pulse.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-low reset
//   req_valid   request present
//   req_ready   high while idle; request taken at an edge with valid&ready
//   req_we      1 = write, 0 = read
//   req_ifetch  read is an instruction fetch (adds an ld_ir cycle)
//   req_addr    target address
//   req_wdata   write data
//   rsp_valid   one-cycle completion pulse
//   rsp_data    last captured read data
//   sel/rd/wr/ld_ir  memory control strobes (registered)
//   address     memory address (registered, holds after a transaction)
//   data_e      shared bidirectional data bus
module mem_bus_master #(
  parameter int AW       = 5,
  parameter int DW       = 8,
  parameter int WR_HOLD  = 2,
  parameter int RD_LAT   = 2,
  parameter int TURN_CYC = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic          req_ifetch,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          sel,
  output logic          rd,
  output logic          wr,
  output logic          ld_ir,
  output logic [AW-1:0] address,
  inout  wire  [DW-1:0] data_e
);

  localparam int MAX_A = (WR_HOLD > RD_LAT) ? WR_HOLD : RD_LAT;
  localparam int MAX_C = (MAX_A > TURN_CYC) ? MAX_A : TURN_CYC;
  localparam int CW    = $clog2(MAX_C + 1);

  // Terminal counts: the counter starts at 0 in the first cycle of a state.
  localparam logic [CW-1:0] WR_LAST   = CW'(WR_HOLD - 1);
  localparam logic [CW-1:0] RD_LAST   = CW'(RD_LAT - 1);
  localparam logic [CW-1:0] TURN_LAST = CW'(TURN_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_LDIR,
    S_TURN
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_sel;
  logic          r_rd;
  logic          r_wr;
  logic          r_ld_ir;
  logic          r_drive;
  logic          r_ifetch;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_rsp_valid;
  logic [DW-1:0] r_rsp_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_sel       <= 1'b0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_ld_ir     <= 1'b0;
      r_drive     <= 1'b0;
      r_ifetch    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_ifetch <= req_ifetch & ~req_we;
            r_cnt    <= '0;
            r_sel    <= 1'b1;
            if (req_we) begin
              r_state <= S_WRITE;
              r_wr    <= 1'b1;
              r_drive <= 1'b1;
            end else begin
              r_state <= S_READ;
              r_rd    <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (r_cnt == WR_LAST) begin
            r_state     <= S_TURN;
            r_cnt       <= '0;
            r_sel       <= 1'b0;
            r_wr        <= 1'b0;
            r_drive     <= 1'b0;
            r_rsp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_READ: begin
          if (r_cnt == RD_LAST) begin
            // Memory has had RD_LAT cycles of rd; sample the bus now.
            r_rsp_data <= data_e;
            r_cnt      <= '0;
            if (r_ifetch) begin
              // sel/rd stay high through the ld_ir cycle.
              r_state <= S_LDIR;
              r_ld_ir <= 1'b1;
            end else begin
              r_state     <= S_TURN;
              r_sel       <= 1'b0;
              r_rd        <= 1'b0;
              r_rsp_valid <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_LDIR: begin
          r_state     <= S_TURN;
          r_sel       <= 1'b0;
          r_rd        <= 1'b0;
          r_ld_ir     <= 1'b0;
          r_rsp_valid <= 1'b1;
        end
        S_TURN: begin
          if (r_cnt == TURN_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign sel       = r_sel;
  assign rd        = r_rd;
  assign wr        = r_wr;
  assign ld_ir     = r_ld_ir;
  assign address   = r_addr;

  // The bus is only ever driven from the WRITE state; a TURN and an IDLE
  // cycle always separate a read from the next write.
  assign data_e = r_drive ? r_wdata : {DW{1'bz}};

endmodule

// File: tb/tb_mem_bus_master.sv
module tb_mem_bus_master;
  localparam int AW       = 5;
  localparam int DW       = 8;
  localparam int WR_HOLD  = 2;
  localparam int RD_LAT   = 2;
  localparam int TURN_CYC = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic          req_ifetch;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          sel;
  logic          rd;
  logic          wr;
  logic          ld_ir;
  logic [AW-1:0] address;
  wire  [DW-1:0] data_e;

  int checks = 0;
  int errors = 0;

  // Memory array seen on the bus and the bench's own expectation of it.
  logic [DW-1:0] mem     [0:(1<<AW)-1] = '{default: '0};
  logic [DW-1:0] ref_mem [0:(1<<AW)-1] = '{default: '0};
  int            wr_run = 0;
  logic [DW-1:0] last_wdata = '0;
  logic [DW-1:0] last_rd    = '0;
  logic [DW-1:0] exp_q [$];

  always #5 clk = ~clk;

  mem_bus_master #(
    .AW(AW), .DW(DW), .WR_HOLD(WR_HOLD), .RD_LAT(RD_LAT), .TURN_CYC(TURN_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_ifetch(req_ifetch),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .sel(sel), .rd(rd), .wr(wr), .ld_ir(ld_ir),
    .address(address), .data_e(data_e)
  );

  // Memory drives during reads. When nobody should drive, the bench parks
  // the bus at zero so that a stray master drive shows up as a conflict.
  assign data_e = (sel && rd) ? mem[address] : (wr ? {DW{1'bz}} : {DW{1'b0}});

  // The memory commits a write only after wr has been held the full hold time.
  always @(posedge clk) begin
    if (sel && wr) begin
      if (wr_run == WR_HOLD - 1) mem[address] <= data_e;
      wr_run <= wr_run + 1;
    end else begin
      wr_run <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and check the bus rules in the new cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("rd_wr_excl", {31'b0, rd && wr}, 32'd0);
    if (wr)              chk("wr_bus", {24'b0, data_e}, {24'b0, last_wdata});
    else if (sel && rd)  chk("rd_bus", {24'b0, data_e}, {24'b0, mem[address]});
    else                 chk("bus_free", {24'b0, data_e}, 32'd0);
  endtask

  task automatic do_req(input logic we, input logic ifetch, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic hold);
    int n;
    int rsp_at;
    int rsp_cnt;
    int rsp_exp;
    int rdy_exp;
    logic is_fetch;
    req_valid  = 1'b1;
    req_we     = we;
    req_ifetch = ifetch;
    req_addr   = addr;
    req_wdata  = wdata;
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    chk("accept_wait", {31'b0, req_ready}, 32'd1);
    is_fetch = ifetch && !we;
    if (we) begin
      ref_mem[addr] = wdata;
      last_wdata    = wdata;
      exp_q.push_back(last_rd);
    end else begin
      last_rd = ref_mem[addr];
      exp_q.push_back(ref_mem[addr]);
    end
    rsp_exp = we ? WR_HOLD + 1 : RD_LAT + 1 + (is_fetch ? 1 : 0);
    rdy_exp = rsp_exp + TURN_CYC;
    tick();                       // accept edge; now in cycle 1
    if (!hold) req_valid = 1'b0;
    n = 1;
    rsp_at = 0;
    rsp_cnt = 0;
    while (!req_ready && n <= 30) begin
      if (n < rsp_exp) begin
        chk("act_sel",  {31'b0, sel}, 32'd1);
        chk("act_wr",   {31'b0, wr},  {31'b0, we});
        chk("act_rd",   {31'b0, rd},  {31'b0, !we});
        chk("act_addr", {27'b0, address}, {27'b0, addr});
      end else begin
        chk("turn_ctl", {28'b0, sel, rd, wr, ld_ir}, 32'd0);
      end
      chk("ld_ir_cyc", {31'b0, ld_ir}, {31'b0, is_fetch && (n == RD_LAT + 1)});
      if (rsp_valid) begin
        rsp_cnt++;
        if (rsp_at == 0) rsp_at = n;
        if (exp_q.size() > 0) chk("rsp_data", {24'b0, rsp_data}, {24'b0, exp_q.pop_front()});
      end
      tick();
      n++;
    end
    chk("rsp_cycle", rsp_at, rsp_exp);
    chk("rsp_count", rsp_cnt, 32'd1);
    chk("ready_cycle", n, rdy_exp);
    chk("idle_rsp_low", {31'b0, rsp_valid}, 32'd0);
    $display("txn we=%0d ifetch=%0d addr=%0d wdata=%0h rsp_at=%0d ready_at=%0d rsp_data=%0h",
             we, ifetch, addr, wdata, rsp_at, n, rsp_data);
  endtask

  initial begin
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_ifetch = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;

    // Reset for two cycles.
    tick();
    tick();
    chk("rst_ctl",       {28'b0, sel, rd, wr, ld_ir}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_addr",      {27'b0, address}, 32'd0);
    chk("rst_rsp_data",  {24'b0, rsp_data}, 32'd0);
    chk("rst_ready",     {31'b0, req_ready}, 32'd1);
    $display("reset ready=%0d addr=%0d rsp_data=%0h", req_ready, address, rsp_data);
    rst = 1'b1;
    tick();

    // Write then read back.
    do_req(1'b1, 1'b0, 5'd0, 8'hAA, 1'b0);
    chk("mem0_hold", {24'b0, mem[0]}, 32'h0000_00AA);
    do_req(1'b0, 1'b0, 5'd0, 8'h00, 1'b0);

    // Write, then instruction fetch of the same word.
    do_req(1'b1, 1'b0, 5'd1, 8'h55, 1'b0);
    do_req(1'b0, 1'b1, 5'd1, 8'h00, 1'b0);

    // Back-to-back with req_valid held high throughout.
    do_req(1'b1, 1'b0, 5'd2, 8'h3C, 1'b1);
    do_req(1'b0, 1'b0, 5'd2, 8'h00, 1'b1);
    req_valid = 1'b0;
    tick();

    // Top address.
    do_req(1'b1, 1'b0, 5'd31, 8'hC3, 1'b0);
    do_req(1'b0, 1'b0, 5'd31, 8'h00, 1'b0);

    // Reset in the first write cycle.
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_ifetch = 1'b0;
    req_addr   = 5'd0;
    req_wdata  = 8'h33;
    last_wdata = 8'h33;
    tick();                       // accept edge
    chk("abort_wr_on", {31'b0, wr}, 32'd1);
    rst       = 1'b0;
    req_valid = 1'b0;
    tick();                       // reset sampled
    chk("abort_ctl",   {28'b0, sel, rd, wr, ld_ir}, 32'd0);
    chk("abort_addr",  {27'b0, address}, 32'd0);
    chk("abort_rsp",   {31'b0, rsp_valid}, 32'd0);
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_rdata", {24'b0, rsp_data}, 32'd0);
    $display("abort ready=%0d wr=%0d rsp_valid=%0d", req_ready, wr, rsp_valid);
    last_rd = '0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    chk("abort_mem0", {24'b0, mem[0]}, 32'h0000_00AA);
    do_req(1'b0, 1'b0, 5'd0, 8'h00, 1'b0);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
